reg_file_mp: RTL and testbench

Parametrised multi-read-port register file for the soft-processor datapath. It generalises the fixed 2-read/1-write file to `NUM_RD` read ports, each with its own enable, one shared write port, register 0 hardwired to zero, and a post-reset clear sequencer. Read-during-write handling is selectable at compile time. It sits between decode (read addresses) and writeback (write port), one per pipeline.

---
 rtl/reg_file_mp.sv | 98 +++++++++
 tb/tb_reg_file_mp.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// reg_file_mp: NUM_RD-read / 1-write register file, r0 reads as zero, with a post-reset clear sequencer.
// Optional macro REGFILE_BYPASS_EN: read-during-write returns the new data (default: old data).
module reg_file_mp #(
  parameter int WIDTH       = 32,
  parameter int NUMREGS     = 32,
  parameter int LOG2NUMREGS = 5,
  parameter int NUM_RD      = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_RD*LOG2NUMREGS-1:0] rd_addr,
  input  logic [NUM_RD-1:0]             rd_en,
  output logic [NUM_RD*WIDTH-1:0]       rd_data,
  input  logic [LOG2NUMREGS-1:0]        wr_addr,
  input  logic [WIDTH-1:0]              wr_data,
  input  logic                          wr_en,
  output logic                          init_busy
);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam logic [LOG2NUMREGS-1:0] LAST_IDX = LOG2NUMREGS'(NUMREGS - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [LOG2NUMREGS-1:0]  r_clr_idx;
  logic [LOG2NUMREGS-1:0]  w_clr_idx_nxt;
  logic [WIDTH-1:0]        r_mem [NUMREGS];
  logic                    w_wr_fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    if (r_state == CLEAR) begin
      w_clr_idx_nxt = r_clr_idx + LOG2NUMREGS'(1);
      if (r_clr_idx == LAST_IDX) begin
        w_state_nxt = READY;
      end
    end
  end

  assign init_busy = (r_state == CLEAR);
  assign w_wr_fire = (r_state == READY) && wr_en && (wr_addr != '0);

  // The sequencer owns the write port while clearing; external writes are dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == CLEAR) begin
        r_mem[r_clr_idx] <= '0;
      end else if (w_wr_fire) begin
        r_mem[wr_addr] <= wr_data;
      end
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [LOG2NUMREGS-1:0] w_addr;
    logic [WIDTH-1:0]       w_val;
    logic [WIDTH-1:0]       r_data;

    assign w_addr = rd_addr[g*LOG2NUMREGS +: LOG2NUMREGS];

    always_comb begin
      w_val = r_mem[w_addr];
      if ((r_state == CLEAR) || (w_addr == '0)) begin
        w_val = '0;
`ifdef REGFILE_BYPASS_EN
      end else if (w_wr_fire && (w_addr == wr_addr)) begin
        w_val = wr_data;
`endif
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        r_data <= '0;
      end else if (rd_en[g]) begin
        r_data <= w_val;
      end
    end

    assign rd_data[g*WIDTH +: WIDTH] = r_data;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp (4 read ports): directed scenarios plus random traffic, scored against
// an array-based model; the driver queues expected outputs and a monitor compares each cycle.
module tb_reg_file_mp;

  localparam int WIDTH   = 32;
  localparam int NUMREGS = 32;
  localparam int LOG2    = 5;
  localparam int NUM_RD  = 4;
  localparam int EW      = NUM_RD*WIDTH + 1;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic [NUM_RD*LOG2-1:0]   rd_addr = '0;
  logic [NUM_RD-1:0]        rd_en = '0;
  logic [NUM_RD*WIDTH-1:0]  rd_data;
  logic [LOG2-1:0]          wr_addr = '0;
  logic [WIDTH-1:0]         wr_data = '0;
  logic                     wr_en = 1'b0;
  logic                     init_busy;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  logic [WIDTH-1:0] m_mem [NUMREGS];
  logic [WIDTH-1:0] m_rd  [NUM_RD];
  int               m_clear_left = NUMREGS;

  reg_file_mp #(
    .WIDTH(WIDTH), .NUMREGS(NUMREGS), .LOG2NUMREGS(LOG2), .NUM_RD(NUM_RD)
  ) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [NUM_RD*LOG2-1:0] pack(input int a0, input int a1, input int a2, input int a3);
    return {LOG2'(a3), LOG2'(a2), LOG2'(a1), LOG2'(a0)};
  endfunction

  // Drive one cycle, advance the model across the coming edge, queue what the DUT must show.
  task automatic cycle(input logic rst, input logic wen, input logic [LOG2-1:0] waddr,
                       input logic [WIDTH-1:0] wdata, input logic [NUM_RD-1:0] ren,
                       input logic [NUM_RD*LOG2-1:0] raddr);
    logic [LOG2-1:0] a;
    logic [EW-1:0]   e;
    reset   = rst;
    wr_en   = wen;
    wr_addr = waddr;
    wr_data = wdata;
    rd_en   = ren;
    rd_addr = raddr;
    for (int p = 0; p < NUM_RD; p++) begin
      a = raddr[p*LOG2 +: LOG2];
      if (rst) m_rd[p] = '0;
      else if (!ren[p]) m_rd[p] = m_rd[p];
      else if (m_clear_left > 0) m_rd[p] = '0;
      else if (a == 0) m_rd[p] = '0;
`ifdef REGFILE_BYPASS_EN
      else if (wen && a == waddr) m_rd[p] = wdata;
`endif
      else m_rd[p] = m_mem[a];
    end
    if (rst) begin
      m_clear_left = NUMREGS;
    end else if (m_clear_left > 0) begin
      m_clear_left--;
      if (m_clear_left == 0) begin
        for (int r = 0; r < NUMREGS; r++) m_mem[r] = '0;
      end
    end else if (wen && waddr != 0) begin
      m_mem[waddr] = wdata;
    end
    e[EW-1] = (m_clear_left > 0);
    for (int p = 0; p < NUM_RD; p++) e[p*WIDTH +: WIDTH] = m_rd[p];
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle_reads(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, 1'b0, '0, '0, 4'hF,
            pack($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31)));
    end
  endtask

  initial begin : monitor
    logic [EW-1:0] got;
    logic [EW-1:0] exp;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        got = {init_busy, rd_data};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL port_chk t=%0t init_busy got=%0b exp=%0b rd_data got=%h exp=%h",
                   $time, got[EW-1], exp[EW-1], got[EW-2:0], exp[EW-2:0]);
        end
      end
    end
  end

  initial begin : driver
    for (int r = 0; r < NUMREGS; r++) m_mem[r] = '0;
    for (int p = 0; p < NUM_RD; p++) m_rd[p] = '0;

    // Reset, then a write dropped during clear, then full clear window with reads.
    repeat (3) cycle(1'b1, 1'b0, '0, '0, 4'hF, pack(1, 2, 3, 4));
    cycle(1'b0, 1'b1, 5'd5, 32'hDEAD, 4'hF, pack(5, 5, 1, 2));
    idle_reads(31);
    cycle(1'b0, 1'b0, '0, '0, 4'h1, pack(5, 0, 0, 0));

    // Basic write/read on all four ports.
    cycle(1'b0, 1'b1, 5'd1, 32'h11, 4'h0, '0);
    cycle(1'b0, 1'b1, 5'd2, 32'h22, 4'h0, '0);
    cycle(1'b0, 1'b1, 5'd3, 32'h33, 4'h0, '0);
    cycle(1'b0, 1'b0, '0, '0, 4'hF, pack(1, 2, 3, 0));

    // r0 ignores writes; disabled port holds.
    cycle(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 4'h0, '0);
    cycle(1'b0, 1'b0, '0, '0, 4'hF, pack(0, 0, 0, 0));
    cycle(1'b0, 1'b0, '0, '0, 4'h2, pack(0, 2, 0, 0));
    cycle(1'b0, 1'b0, '0, '0, 4'hD, pack(1, 3, 1, 1));

    // Collision on r7, then same-address multi-port read.
    cycle(1'b0, 1'b1, 5'd7, 32'hAAAA, 4'h0, '0);
    cycle(1'b0, 1'b1, 5'd7, 32'hBBBB, 4'h1, pack(7, 0, 0, 0));
    cycle(1'b0, 1'b0, '0, '0, 4'hF, pack(7, 7, 7, 7));

    // Reset mid-clear, then read every register.
    cycle(1'b1, 1'b0, '0, '0, 4'h0, '0);
    idle_reads(10);
    cycle(1'b1, 1'b0, '0, '0, 4'h0, '0);
    idle_reads(32);
    for (int k = 0; k < NUMREGS/4; k++) begin
      cycle(1'b0, 1'b0, '0, '0, 4'hF, pack(4*k, 4*k+1, 4*k+2, 4*k+3));
    end

    // Back-to-back writes to r4 with port 0 reading every cycle.
    cycle(1'b0, 1'b1, 5'd4, 32'd1, 4'h1, pack(4, 0, 0, 0));
    cycle(1'b0, 1'b1, 5'd4, 32'd2, 4'h1, pack(4, 0, 0, 0));
    cycle(1'b0, 1'b1, 5'd4, 32'd3, 4'h1, pack(4, 0, 0, 0));
    cycle(1'b0, 1'b0, '0, '0, 4'h1, pack(4, 0, 0, 0));

    // Random traffic on a small address window to provoke collisions; rare resets.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            $urandom, 4'($urandom_range(0, 15)),
            pack($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)));
    end

    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
